// File: rtl/lvg_sequencer_if.sv
// lvg_sequencer_if: host/core-facing bundle of the lvg micro-sequencer.
//   prog_we/prog_addr/prog_data : program memory write port (host -> sequencer)
//   start                       : run request, level sampled while idle
//   instr_out                   : registered instruction word to the core
//   busy / done                 : program executing / one-cycle end pulse
//   pc                          : current fetch address
// The master modport is the host side, the slave modport the sequencer.
interface lvg_sequencer_if #(
  parameter int AW = 6
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          start;
  logic [15:0]   instr_out;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;

  modport master (
    output prog_we, prog_addr, prog_data, start,
    input  instr_out, busy, done, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start,
    output instr_out, busy, done, pc
  );
endinterface

// File: rtl/lvg_sequencer.sv
// lvg_sequencer: micro-sequencer feeding the lvg core one 16-bit instruction
// per cycle from a host-loaded program memory.
//   clk, rst : clock and synchronous active-high reset
//   bus      : lvg_sequencer_if.slave (program write port, start, instr_out,
//              busy, done, pc)
// MATMUL (opcode 3) is held for exactly MM_CYCLES cycles and always followed
// by one zero cycle so the core sees a fresh opcode-3 edge per matmul.
// WAIT n (opcode 0xFE, n in [15:8]) produces n+1 zero cycles. HALT (0xFF) or
// running past the last word ends the program with a one-cycle done pulse.
module lvg_sequencer #(
  parameter int DEPTH     = 64,
  parameter int AW        = 6,
  parameter int MM_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  lvg_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_WAIT = 2'd3
  } state_e;

  localparam logic [7:0]    OP_MATMUL = 8'h03;
  localparam logic [7:0]    OP_WAIT   = 8'hFE;
  localparam logic [7:0]    OP_HALT   = 8'hFF;
  localparam logic [7:0]    MM_LAST   = 8'(MM_CYCLES - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [15:0]   mem_q [DEPTH];
  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [15:0]   instr_q;
  logic          busy_q;
  logic          done_q;
  logic [7:0]    cnt_q;
  // Set once the word at the last address has been issued; the next RUN
  // cycle then finishes the program exactly like a fetched HALT.
  logic          end_q;
  logic [15:0]   word_s;

  assign word_s = mem_q[pc_q];

  assign bus.instr_out = instr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pc        = pc_q;

  // Program memory write port; writes are dropped while a program runs.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !busy_q) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  // Sequencer FSM with registered instruction, status and counter outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 8'h00;
      end_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          instr_q <= 16'h0000;
          if (bus.start) begin
            pc_q    <= '0;
            busy_q  <= 1'b1;
            end_q   <= 1'b0;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          if (end_q || (word_s[7:0] == OP_HALT)) begin
            // pc is left on the HALT (or last) address.
            instr_q <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            // pc never wraps: the last word arms end_q instead.
            if (pc_q == LAST_ADDR) begin
              end_q <= 1'b1;
            end else begin
              pc_q <= pc_q + AW'(1);
            end
            case (word_s[7:0])
              OP_MATMUL: begin
                instr_q <= word_s;
                cnt_q   <= MM_LAST;
                state_q <= S_HOLD;
              end
              OP_WAIT: begin
                instr_q <= 16'h0000;
                // WAIT 0 is just this zero cycle; WAIT n adds n more.
                if (word_s[15:8] != 8'h00) begin
                  cnt_q   <= word_s[15:8];
                  state_q <= S_WAIT;
                end
              end
              default: begin
                instr_q <= word_s;
              end
            endcase
          end
        end

        S_HOLD: begin
          // The RUN cycle already showed the matmul once, so cnt starts at
          // MM_CYCLES-1; the drop to zero here gives the separating NOP.
          if (cnt_q != 8'h00) begin
            cnt_q <= cnt_q - 8'h01;
          end else begin
            instr_q <= 16'h0000;
            state_q <= S_RUN;
          end
        end

        S_WAIT: begin
          instr_q <= 16'h0000;
          if (cnt_q == 8'h01) begin
            state_q <= S_RUN;
          end else begin
            cnt_q <= cnt_q - 8'h01;
          end
        end

        default: begin
          instr_q <= 16'h0000;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lvg_sequencer.sv
module tb_lvg_sequencer;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int MM    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [15:0] prog [DEPTH];
  logic [15:0] exp_q[$];
  int          exp_pc;
  logic [15:0] obs_instr[$];
  logic        obs_done[$];
  logic        obs_busy[$];
  logic [15:0] c1_instr;
  logic        c1_busy;
  logic [AW-1:0] final_pc;

  lvg_sequencer_if #(.AW(AW)) bus ();

  lvg_sequencer #(.DEPTH(DEPTH), .AW(AW), .MM_CYCLES(MM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: expected instr_out stream from cycle 2 on; last entry is the done cycle.
  task automatic build_model();
    logic [15:0] w;
    exp_q.delete();
    for (int p = 0; p < DEPTH; p++) begin
      w = prog[p];
      if (w[7:0] == 8'hFF) begin
        exp_q.push_back(16'h0000);
        exp_pc = p;
        break;
      end
      if (w[7:0] == 8'h03) begin
        for (int k = 0; k < MM; k++) exp_q.push_back(w);
        exp_q.push_back(16'h0000);
      end else if (w[7:0] == 8'hFE) begin
        for (int k = 0; k <= int'(w[15:8]); k++) exp_q.push_back(16'h0000);
      end else begin
        exp_q.push_back(w);
      end
      if (p == DEPTH - 1) begin
        exp_q.push_back(16'h0000);
        exp_pc = p;
      end
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < DEPTH; i++) prog[i] = v;
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = AW'(i);
      bus.prog_data = prog[i];
      tick();
    end
    bus.prog_we = 1'b0;
  endtask

  // Starts the program and records outputs; optional disturbance at step intf_k,
  // optional write of prog[0] in the same cycle as start.
  task automatic run_capture(input int intf_k, input bit wr0);
    int limit;
    build_model();
    obs_instr.delete();
    obs_done.delete();
    obs_busy.delete();
    limit = exp_q.size() + 8;
    if (wr0) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = '0;
      bus.prog_data = prog[0];
    end
    bus.start = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    c1_instr = bus.instr_out;
    c1_busy  = bus.busy;
    for (int k = 0; k < limit; k++) begin
      if (k == intf_k) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = '0;
        bus.prog_data = 16'hBEEF;
        bus.start     = 1'b1;
      end
      tick();
      bus.prog_we = 1'b0;
      bus.start   = 1'b0;
      obs_instr.push_back(bus.instr_out);
      obs_done.push_back(bus.done);
      obs_busy.push_back(bus.busy);
      if (bus.done) break;
    end
    final_pc = bus.pc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.prog_we = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = 16'h0000;
    bus.start = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.instr_out !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pc !== 6'd0) begin
      failures++;
      $display("FAIL reset instr=%h busy=%b done=%b pc=%0d expected 0000/0/0/0",
               bus.instr_out, bus.busy, bus.done, bus.pc);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int last;
    fill(16'h00FF);
    prog[0] = 16'h0001;
    prog[1] = 16'h0002;
    load_prog();
    run_capture(-1, 1'b0);
    last = exp_q.size() - 1;
    checks++;
    if (c1_instr !== 16'h0000 || c1_busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_cycle1 instr=%h busy=%b expected 0000/1", c1_instr, c1_busy);
    end
    checks++;
    if (obs_instr.size() != 3 || exp_q.size() != 3) begin
      failures++;
      $display("FAIL basic_len got=%0d expected=3", obs_instr.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_instr.size(); i++) begin
      checks++;
      if (obs_instr[i] !== exp_q[i] || obs_done[i] !== (i == last) || obs_busy[i] !== (i != last)) begin
        failures++;
        $display("FAIL basic_c%0d instr=%h done=%b busy=%b expected instr=%h done=%b",
                 i + 2, obs_instr[i], obs_done[i], obs_busy[i], exp_q[i], (i == last));
      end
    end
  endtask

  task automatic test_matmul();
    int last, n1203;
    fill(16'h00FF);
    prog[0] = 16'h1203;
    load_prog();
    run_capture(-1, 1'b0);
    last = exp_q.size() - 1;
    n1203 = 0;
    foreach (obs_instr[i]) if (obs_instr[i] === 16'h1203) n1203++;
    checks++;
    if (n1203 != MM || obs_instr.size() != MM + 2) begin
      failures++;
      $display("FAIL matmul_hold count=%0d len=%0d expected count=%0d len=%0d", n1203, obs_instr.size(), MM, MM + 2);
    end
    for (int i = 0; i < exp_q.size() && i < obs_instr.size(); i++) begin
      checks++;
      if (obs_instr[i] !== exp_q[i] || obs_done[i] !== (i == last) || obs_busy[i] !== (i != last)) begin
        failures++;
        if (failures < 20)
          $display("FAIL matmul_c%0d instr=%h done=%b expected instr=%h done=%b",
                   i + 2, obs_instr[i], obs_done[i], exp_q[i], (i == last));
      end
    end
    checks++;
    if (final_pc !== 6'd1) begin
      failures++;
      $display("FAIL matmul_pc got=%0d expected=1", final_pc);
    end
  endtask

  task automatic test_back_to_back();
    int last;
    fill(16'h00FF);
    prog[0] = 16'h0003;
    prog[1] = 16'h0003;
    load_prog();
    run_capture(-1, 1'b0);
    last = exp_q.size() - 1;
    checks++;
    if (obs_instr.size() != 2 * MM + 3) begin
      failures++;
      $display("FAIL b2b_len got=%0d expected=%0d", obs_instr.size(), 2 * MM + 3);
    end
    for (int i = 0; i < exp_q.size() && i < obs_instr.size(); i++) begin
      checks++;
      if (obs_instr[i] !== exp_q[i] || obs_done[i] !== (i == last) || obs_busy[i] !== (i != last)) begin
        failures++;
        if (failures < 20)
          $display("FAIL b2b_c%0d instr=%h done=%b expected instr=%h done=%b",
                   i + 2, obs_instr[i], obs_done[i], exp_q[i], (i == last));
      end
    end
  endtask

  task automatic test_wait();
    logic [15:0] wwords [2];
    int          wexp   [2];
    int          zeros;
    wwords[0] = 16'h05FE; wexp[0] = 6;
    wwords[1] = 16'h00FE; wexp[1] = 1;
    for (int t = 0; t < 2; t++) begin
      fill(16'h00FF);
      prog[0] = wwords[t];
      prog[1] = 16'h0001;
      load_prog();
      run_capture(-1, 1'b0);
      zeros = 0;
      while (zeros < obs_instr.size() && obs_instr[zeros] === 16'h0000) zeros++;
      checks++;
      if (zeros != wexp[t] || zeros >= obs_instr.size() || obs_instr[zeros] !== 16'h0001) begin
        failures++;
        $display("FAIL wait_%h zeros=%0d expected=%0d then 0001", wwords[t], zeros, wexp[t]);
      end
      checks++;
      if (obs_instr.size() != exp_q.size() || obs_done[obs_done.size() - 1] !== 1'b1) begin
        failures++;
        $display("FAIL wait_%h_end len=%0d expected=%0d", wwords[t], obs_instr.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_end_of_mem();
    int last;
    fill(16'h0001);
    load_prog();
    run_capture(-1, 1'b0);
    last = exp_q.size() - 1;
    checks++;
    if (obs_instr.size() != DEPTH + 1) begin
      failures++;
      $display("FAIL eom_len got=%0d expected=%0d", obs_instr.size(), DEPTH + 1);
    end
    for (int i = 0; i < exp_q.size() && i < obs_instr.size(); i++) begin
      checks++;
      if (obs_instr[i] !== exp_q[i] || obs_done[i] !== (i == last) || obs_busy[i] !== (i != last)) begin
        failures++;
        if (failures < 20)
          $display("FAIL eom_c%0d instr=%h done=%b expected instr=%h done=%b",
                   i + 2, obs_instr[i], obs_done[i], exp_q[i], (i == last));
      end
    end
    repeat (3) tick();
    checks++;
    if (final_pc !== 6'd63 || bus.pc !== 6'd63 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL eom_pc done_pc=%0d later_pc=%0d busy=%b expected 63/63/0", final_pc, bus.pc, bus.busy);
    end
  endtask

  task automatic test_write_with_start();
    fill(16'h00FF);
    prog[0] = 16'h0001;
    load_prog();
    prog[0] = 16'h0002;
    run_capture(-1, 1'b1);
    checks++;
    if (obs_instr.size() < 1 || obs_instr[0] !== 16'h0002) begin
      failures++;
      $display("FAIL write_start first=%h expected=0002", obs_instr.size() > 0 ? obs_instr[0] : 16'hxxxx);
    end
  endtask

  task automatic test_hold_interference();
    int last;
    fill(16'h00FF);
    prog[0] = 16'h1203;
    prog[1] = 16'h0001;
    load_prog();
    for (int pass = 0; pass < 2; pass++) begin
      // first pass: write+start during HOLD; second pass: read back via rerun
      run_capture(pass == 0 ? 3 : -1, 1'b0);
      last = exp_q.size() - 1;
      checks++;
      if (obs_instr.size() != exp_q.size()) begin
        failures++;
        $display("FAIL hold_p%0d_len got=%0d expected=%0d", pass, obs_instr.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_instr.size(); i++) begin
        checks++;
        if (obs_instr[i] !== exp_q[i] || obs_done[i] !== (i == last) || obs_busy[i] !== (i != last)) begin
          failures++;
          if (failures < 20)
            $display("FAIL hold_p%0d_c%0d instr=%h done=%b expected instr=%h done=%b",
                     pass, i + 2, obs_instr[i], obs_done[i], exp_q[i], (i == last));
        end
      end
    end
  endtask

  task automatic test_reset_in_hold();
    int dones;
    fill(16'h00FF);
    prog[0] = 16'h1203;
    load_prog();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    checks++;
    if (bus.instr_out !== 16'h1203 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL rsthold_pre instr=%h busy=%b expected 1203/1", bus.instr_out, bus.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.instr_out !== 16'h0000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pc !== 6'd0) begin
      failures++;
      $display("FAIL rsthold_post instr=%h busy=%b done=%b pc=%0d expected 0000/0/0/0",
               bus.instr_out, bus.busy, bus.done, bus.pc);
    end
    dones = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (bus.done === 1'b1 || bus.instr_out !== 16'h0000) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL rsthold_abandon activity_cycles=%0d expected=0", dones);
    end
  endtask

  task automatic test_random();
    int r, last;
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        r = $urandom_range(0, 99);
        if (r < 25)      prog[i] = {8'($urandom_range(0, 255)), 8'h01};
        else if (r < 45) prog[i] = {8'($urandom_range(0, 255)), 8'h02};
        else if (r < 55) prog[i] = {8'($urandom_range(0, 255)), 8'h03};
        else if (r < 67) prog[i] = {8'($urandom_range(0, 6)), 8'hFE};
        else if (r < 80) prog[i] = {8'($urandom_range(0, 255)), 8'($urandom_range(4, 253))};
        else             prog[i] = {8'($urandom_range(0, 255)), 8'h00};
      end
      if (it % 2 == 0) prog[$urandom_range(3, DEPTH - 1)] = {8'($urandom_range(0, 255)), 8'hFF};
      load_prog();
      run_capture(-1, 1'b0);
      last = exp_q.size() - 1;
      checks++;
      if (obs_instr.size() != exp_q.size() || final_pc !== 6'(exp_pc)) begin
        failures++;
        $display("FAIL rand%0d_len len=%0d pc=%0d expected len=%0d pc=%0d",
                 it, obs_instr.size(), final_pc, exp_q.size(), exp_pc);
      end
      for (int i = 0; i < exp_q.size() && i < obs_instr.size(); i++) begin
        checks++;
        if (obs_instr[i] !== exp_q[i] || obs_done[i] !== (i == last) || obs_busy[i] !== (i != last)) begin
          failures++;
          if (failures < 20)
            $display("FAIL rand%0d_c%0d instr=%h done=%b expected instr=%h done=%b",
                     it, i + 2, obs_instr[i], obs_done[i], exp_q[i], (i == last));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_matmul();
    test_back_to_back();
    test_wait();
    test_end_of_mem();
    test_write_with_start();
    test_hold_interference();
    test_reset_in_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lvg_sequencer.md
Name: lvg_sequencer

Overview:
- Micro-sequencer upstream of the lvg core; generates the 16-bit instr stream each cycle from a small host-loaded program memory.
- Guarantees the core's timing contract: LOADL/LOADR are one-cycle ops, MATMUL (opcode 3) is held for exactly MM_CYCLES consecutive cycles and is followed by at least one NOP, so the core sees a fresh opcode-3 edge for every matmul.
- Host loads the program, pulses start, and waits for done.

Parameters:
- DEPTH, 64, program memory words.
- AW, 6, program address width (clog2 DEPTH).
- MM_CYCLES, 16, cycles opcode 3 is held on instr_out (legal range 1..255).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- prog_we  input  1  program write strobe
- prog_addr  input  AW  program write address
- prog_data  input  16  program word: [7:0] opcode, [15:8] operand/addr
- start  input  1  begin execution at pc=0 (level sampled, honoured only in IDLE)
- instr_out  output  16  registered instruction to core instr; [7:0] opcode, [15:8] addr
- busy  output  1  program executing
- done  output  1  one-cycle pulse at program end
- pc  output  AW  current fetch address

Behaviour:
- Reset: state=IDLE, pc=0, instr_out=0, busy=0, done=0, cnt=0. Memory contents are not cleared. Reset mid-run forces instr_out=0 on the next cycle and abandons the program with no done pulse.
- Memory: reg array, written on posedge when prog_we && !busy. Writes while busy are dropped. Read is asynchronous at pc.
- Opcodes: 0 NOP, 1 LOADL, 2 LOADR, 3 MATMUL, 0xFE WAIT, 0xFF HALT. Any other value (4..0xFD) passes through like NOP (one cycle, word emitted unchanged).
- States: IDLE, RUN, HOLD, WAIT.
- IDLE: instr_out=0. When start=1, pc<=0, busy<=1, go to RUN.
- RUN: decodes w=mem[pc]; the result is visible on instr_out the next cycle.
  - Opcodes 0,1,2 and other pass-through values: instr_out<=w, pc<=pc+1, stay in RUN.
  - 3: instr_out<=w, cnt<=MM_CYCLES-1, pc<=pc+1, go to HOLD.
  - 0xFE: instr_out<=0, pc<=pc+1. If w[15:8]==0, stay in RUN. Otherwise cnt<=w[15:8] and go to WAIT.
  - 0xFF: instr_out<=0, busy<=0, done<=1, go to IDLE. pc holds the HALT address.
- HOLD: instr_out is held. If cnt!=0, cnt<=cnt-1. If cnt==0, instr_out<=0 and go to RUN.
  - Net timing: opcode 3 is visible for exactly MM_CYCLES cycles, then exactly one 0 cycle before the next word.
- WAIT: instr_out=0. If cnt==1, go to RUN; otherwise cnt<=cnt-1.
  - Net timing: WAIT n produces exactly n+1 NOP cycles (n=0..255).
- End of memory: when the word at DEPTH-1 is not HALT, it executes fully (including its HOLD/WAIT). Execution then ends as if a HALT were fetched: instr_out=0, done pulse, busy=0, pc stays at DEPTH-1. pc never wraps.
- done: high for exactly one cycle, the same cycle busy first reads 0.
- busy: high from the cycle after start is accepted until done.
- start while busy is ignored. start held high in IDLE after done restarts on the next cycle.
- Simultaneous prog_we and start in IDLE: the write completes, then RUN fetches the new contents.

Test Plan:
- Load {0x0001,0x0002,0xFF}, pulse start at cycle 0:
  - instr_out = 0x0001 at cycle 2, 0x0002 at cycle 3, 0 at cycle 4.
  - done=1 and busy=0 at cycle 4.
- Load {0x1203, 0x00FF} with MM_CYCLES=16:
  - instr_out = 0x1203 for exactly 16 consecutive cycles, then 0.
  - done one cycle later. pc ends at 1.
- Two back-to-back 0x0003 words:
  - two 16-cycle opcode-3 runs separated by exactly one 0 cycle.
- 0x05FE followed by 0x0001:
  - exactly 6 zero cycles before 0x0001 appears.
  - 0x00FE gives exactly 1 zero cycle.
- Fill all 64 words with 0x0001 and no HALT:
  - 64 cycles of 0x0001, then done pulse.
  - pc=63, no wrap to 0.
- Mid-HOLD behaviour:
  - prog_we to address 0 during HOLD leaves memory unchanged on readback.
  - start during HOLD is ignored.
  - rst asserted at HOLD cycle 5 gives instr_out=0, busy=0, done=0 the next cycle.
